// File: rtl/mem_access_ctrl_if.sv
// Core-side request, store-data and load-data handshakes for the memory access controller.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_len;

  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;

  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rready;

  logic              done;

  modport master (
    output req_valid, req_write, req_addr, req_len, wdata, wvalid, rready,
    input  req_ready, wready, rdata, rvalid, done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wdata, wvalid, rready,
    output req_ready, wready, rdata, rvalid, done
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Bus-master front end sequencing single/burst loads and stores onto the 32x8 data memory.
// Store 2 cycles/beat, load READ_LAT+2 cycles/beat; wvalid and rready stalls hold the burst indefinitely.
module mem_access_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read_write
);

  localparam int LAT_W = $clog2(READ_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_STROBE,
    RD_ISSUE,
    RD_WAIT,
    RD_HOLD,
    DONE
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] cur_addr, cur_addr_d;
  logic [ADDR_W-1:0] beat, beat_d;
  logic [ADDR_W-1:0] len, len_d;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_data_out_d;
  logic [DATA_W-1:0] rdata_d;
  logic              last_beat;

  assign last_beat = (beat == len);

  always_comb begin
    state_d        = state;
    cur_addr_d     = cur_addr;
    beat_d         = beat;
    len_d          = len;
    lat_cnt_d      = lat_cnt;
    mem_addr_d     = mem_addr;
    mem_data_out_d = mem_data_out;
    rdata_d        = bus.rdata;

    unique case (state)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          cur_addr_d = bus.req_addr;
          len_d      = bus.req_len;
          beat_d     = '0;
          state_d    = bus.req_write ? WR_WAIT : RD_ISSUE;
        end
      end
      WR_WAIT: begin
        if (bus.wvalid && bus.wready) begin
          mem_data_out_d = bus.wdata;
          mem_addr_d     = cur_addr;
          state_d        = WR_STROBE;
        end
      end
      WR_STROBE: begin
        if (last_beat) begin
          state_d = DONE;
        end else begin
          beat_d     = beat + ADDR_W'(1);
          cur_addr_d = cur_addr + ADDR_W'(1);
          state_d    = WR_WAIT;
        end
      end
      RD_ISSUE: begin
        lat_cnt_d = LAT_W'(READ_LAT);
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        // Capture on the cycle the count reaches zero; the address has been stable READ_LAT cycles by then.
        lat_cnt_d = lat_cnt - LAT_W'(1);
        if (lat_cnt == LAT_W'(1)) begin
          rdata_d = mem_data_in;
          state_d = RD_HOLD;
        end
      end
      RD_HOLD: begin
        if (bus.rvalid && bus.rready) begin
          if (last_beat) begin
            state_d = DONE;
          end else begin
            beat_d     = beat + ADDR_W'(1);
            cur_addr_d = cur_addr + ADDR_W'(1);
            state_d    = RD_ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Presenting the read address on entry to RD_ISSUE keeps the load pipeline at READ_LAT+2 per beat.
    if (state_d == RD_ISSUE) begin
      mem_addr_d = cur_addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cur_addr       <= '0;
      beat           <= '0;
      len            <= '0;
      lat_cnt        <= '0;
      mem_addr       <= '0;
      mem_data_out   <= '0;
      mem_read_write <= 1'b0;
      bus.req_ready  <= 1'b0;
      bus.wready     <= 1'b0;
      bus.rdata      <= '0;
      bus.rvalid     <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      state          <= state_d;
      cur_addr       <= cur_addr_d;
      beat           <= beat_d;
      len            <= len_d;
      lat_cnt        <= lat_cnt_d;
      mem_addr       <= mem_addr_d;
      mem_data_out   <= mem_data_out_d;
      mem_read_write <= (state_d == WR_STROBE);
      bus.req_ready  <= (state_d == IDLE);
      bus.wready     <= (state_d == WR_WAIT);
      bus.rdata      <= rdata_d;
      bus.rvalid     <= (state_d == RD_HOLD);
      bus.done       <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized bursts against a 32x8 memory model; writes and reads are scored against a plain array model.
module tb_mem_access_ctrl;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 8;
  localparam int READ_LAT = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read_write;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .mem_addr       (mem_addr),
    .mem_data_out   (mem_data_out),
    .mem_data_in    (mem_data_in),
    .mem_read_write (mem_read_write)
  );

  always #5 clk = ~clk;

  // Memory attached to the controller: synchronous write, READ_LAT-cycle read.
  bit   [7:0] mem_arr [32];
  logic [7:0] rd_pipe [READ_LAT];
  assign mem_data_in = rd_pipe[READ_LAT-1];

  logic [4:0] wr_a_q [$];
  logic [7:0] wr_d_q [$];
  int         done_cnt = 0;

  always @(posedge clk) begin
    if (mem_read_write) begin
      mem_arr[mem_addr] <= mem_data_out;
      wr_a_q.push_back(mem_addr);
      wr_d_q.push_back(mem_data_out);
    end
    rd_pipe[0] <= mem_arr[mem_addr];
    for (int k = 1; k < READ_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    if (bus.done) done_cnt++;
  end

  bit   [7:0] ref_mem [32];
  bit         ref_unk [32];
  logic [7:0] wq [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_wq(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
  endtask

  task automatic send_req(input logic w, input logic [4:0] a, input logic [4:0] l);
    int t = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_len   = l;
    while (bus.req_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("req_ready_seen", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("req_ready_busy", 32'(bus.req_ready), 32'd0);
  endtask

  task automatic push_beat(input logic [7:0] d);
    int t = 0;
    bus.wdata  = d;
    bus.wvalid = 1'b1;
    while (bus.wready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("wready_seen", 32'(bus.wready), 32'd1);
    @(negedge clk);
    bus.wvalid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (bus.done !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    check("done_seen", 32'(bus.done), 32'd1);
    check("ready_in_done", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("ready_after_done", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_store(input logic [4:0] a, input logic [4:0] l, input int stall0, input int max_stall);
    int         base_w, base_d, k;
    logic [4:0] ea;
    base_w = wr_a_q.size();
    base_d = done_cnt;
    bus.wvalid = 1'b0;
    send_req(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      k = (i == 0) ? stall0 : $urandom_range(max_stall, 0);
      for (int s = 0; s < k; s++) begin
        if (i == 0) begin
          check("wstall_wready", 32'(bus.wready), 32'd1);
          check("wstall_no_write", 32'(mem_read_write), 32'd0);
        end
        @(negedge clk);
      end
      push_beat(wq[i]);
    end
    wait_done();
    check("wr_count", 32'(wr_a_q.size() - base_w), 32'(int'(l) + 1));
    for (int i = 0; i <= int'(l); i++) begin
      ea = a + 5'(i);
      if (base_w + i < wr_a_q.size()) begin
        check("wr_addr", 32'(wr_a_q[base_w+i]), 32'(ea));
        check("wr_data", 32'(wr_d_q[base_w+i]), 32'(wq[i]));
      end
      ref_mem[ea] = wq[i];
      ref_unk[ea] = 1'b0;
    end
    check("wr_done_count", 32'(done_cnt - base_d), 32'd1);
  endtask

  task automatic do_load(input logic [4:0] a, input logic [4:0] l, input int hold0, input int max_stall);
    int         base_w, base_d, t, k;
    logic [4:0] ea, a0;
    logic [7:0] d0;
    base_w = wr_a_q.size();
    base_d = done_cnt;
    // Stray store beats throughout the load must never reach memory.
    bus.wvalid = 1'b1;
    bus.wdata  = 8'hEE;
    send_req(1'b0, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      ea = a + 5'(i);
      t  = 0;
      while (bus.rvalid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      check("rvalid_seen", 32'(bus.rvalid), 32'd1);
      check("rd_addr", 32'(mem_addr), 32'(ea));
      if (!ref_unk[ea]) check("rdata", 32'(bus.rdata), 32'(ref_mem[ea]));
      k  = (i == 0) ? hold0 : $urandom_range(max_stall, 0);
      d0 = bus.rdata;
      a0 = mem_addr;
      for (int s = 0; s < k; s++) begin
        @(negedge clk);
        check("bp_rvalid", 32'(bus.rvalid), 32'd1);
        check("bp_rdata", 32'(bus.rdata), 32'(d0));
        check("bp_addr", 32'(mem_addr), 32'(a0));
        check("bp_no_done", 32'(bus.done), 32'd0);
      end
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;
      check("rvalid_drop", 32'(bus.rvalid), 32'd0);
    end
    bus.wvalid = 1'b0;
    wait_done();
    check("rd_no_write", 32'(wr_a_q.size() - base_w), 32'd0);
    check("rd_done_count", 32'(done_cnt - base_d), 32'd1);
  endtask

  initial begin
    logic [4:0] ra, rl;
    int         base_w;

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wdata     = '0;
    bus.wvalid    = 1'b0;
    bus.rready    = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_wready", 32'(bus.wready), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data_out", 32'(mem_data_out), 32'd0);
    check("rst_mem_rw", 32'(mem_read_write), 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.req_ready), 32'd1);

    // Single store then load at address 5.
    wq.delete(); wq.push_back(8'hA5);
    do_store(5'd5, 5'd0, 0, 0);
    do_load(5'd5, 5'd0, 0, 0);

    // Burst across the 31 -> 0 wrap.
    wq.delete();
    wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33); wq.push_back(8'h44);
    do_store(5'd30, 5'd3, 0, 0);
    do_load(5'd30, 5'd3, 0, 0);

    // Load backpressure: first beat held for 10 cycles.
    do_load(5'd30, 5'd1, 10, 0);

    // Store stall: wvalid withheld 5 cycles before the only beat.
    wq.delete(); wq.push_back(8'h5A);
    do_store(5'd9, 5'd0, 5, 0);
    do_load(5'd9, 5'd0, 0, 0);

    // Full 32-beat store and readback.
    fill_wq(32);
    do_store(5'd0, 5'd31, 0, 0);
    do_load(5'd0, 5'd31, 0, 0);

    // Reset during the strobe of beat 2 of a 4-beat store.
    fill_wq(4);
    base_w = wr_a_q.size();
    send_req(1'b1, 5'd12, 5'd3);
    for (int i = 0; i < 3; i++) push_beat(wq[i]);
    check("strobe_beat2", 32'(mem_read_write), 32'd1);
    check("pre_rst_writes", 32'(wr_a_q.size() - base_w), 32'd2);
    bus.wvalid = 1'b1;
    bus.wdata  = wq[3];
    rst_n      = 1'b0;
    #1;
    check("rst_mid_rw", 32'(mem_read_write), 32'd0);
    check("rst_mid_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("rst_mid_rw_hold", 32'(mem_read_write), 32'd0);
    check("rst_mid_ready_hold", 32'(bus.req_ready), 32'd0);
    bus.wvalid = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);
    check("ready_after_mid_rst", 32'(bus.req_ready), 32'd1);
    check("post_rst_writes", 32'(wr_a_q.size() - base_w), 32'd2);
    ref_mem[12] = wq[0]; ref_unk[12] = 1'b0;
    ref_mem[13] = wq[1]; ref_unk[13] = 1'b0;
    ref_unk[14] = 1'b1;
    do_load(5'd12, 5'd2, 0, 0);

    // Randomized bursts with random stalls on both streams.
    for (int n = 0; n < 8; n++) begin
      ra = 5'($urandom);
      rl = 5'($urandom_range(7, 0));
      fill_wq(int'(rl) + 1);
      do_store(ra, rl, $urandom_range(3, 0), 2);
      do_load(ra, rl, $urandom_range(3, 0), 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
